imem_boot_loader: RTL and testbench

//  Byte-stream program loader upstream of the pipeline's instruction memory (imem).

---
 rtl/imem_boot_loader.sv | 141 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: framed byte-stream image loader for instruction memory.
// Holds the core in reset until a checksum-verified image has been written.
module imem_boot_loader #(
    parameter int WIDTH = 32,
    parameter int INDEX = 6
) (
    input  logic             clk_in,
    input  logic             nrst_in,
    input  logic             byte_valid_in,
    input  logic [7:0]       byte_data_in,
    output logic             byte_ready_out,
    input  logic             reload_in,
    output logic             imem_we_out,
    output logic [INDEX-1:0] imem_addr_out,
    output logic [WIDTH-1:0] imem_data_out,
    output logic             core_nrst_out,
    output logic             done_out,
    output logic             err_out,
    output logic [INDEX:0]   words_loaded_out
);

    localparam int unsigned DEPTH = 1 << INDEX;

    typedef enum logic [2:0] {
        S_HDR_LO,
        S_HDR_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t state;
    state_t state_nx;

    logic [7:0]     cnt_lo;
    logic [INDEX:0] n_words;
    logic [7:0]     xsum;
    logic [INDEX:0] word_idx;
    logic [1:0]     bidx;
    logic [23:0]    wbuf;

    logic           xfer;
    logic           reload_go;
    logic [15:0]    hdr_n;
    logic [INDEX:0] idx_inc;

    assign byte_ready_out = (state == S_HDR_LO) || (state == S_HDR_HI) ||
                            (state == S_DATA)   || (state == S_CSUM);
    assign xfer      = byte_valid_in & byte_ready_out;
    assign reload_go = reload_in & ((state == S_DONE) || (state == S_ERR));
    assign hdr_n     = {byte_data_in, cnt_lo};
    assign idx_inc   = word_idx + (INDEX+1)'(1);
    assign done_out  = (state == S_DONE);
    assign err_out   = (state == S_ERR);

    // Frame sequencing: header, payload words, checksum, then terminal state.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_HDR_LO: if (xfer) state_nx = S_HDR_HI;
            S_HDR_HI: begin
                if (xfer) begin
                    if (hdr_n > 16'(DEPTH))  state_nx = S_ERR;
                    else if (hdr_n == 16'd0) state_nx = S_CSUM;
                    else                     state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer && bidx == 2'd3 && idx_inc == n_words)
                    state_nx = S_CSUM;
            end
            S_CSUM: begin
                if (xfer)
                    state_nx = (byte_data_in == xsum) ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: if (reload_in) state_nx = S_HDR_LO;
            default: state_nx = S_HDR_LO;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) state <= S_HDR_LO;
        else          state <= state_nx;
    end

    // Header capture, word assembly, checksum and registered imem write.
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            cnt_lo           <= '0;
            n_words          <= '0;
            xsum             <= '0;
            word_idx         <= '0;
            bidx             <= '0;
            wbuf             <= '0;
            imem_we_out      <= 1'b0;
            imem_addr_out    <= '0;
            imem_data_out    <= '0;
            core_nrst_out    <= 1'b0;
            words_loaded_out <= '0;
        end else begin
            imem_we_out   <= 1'b0;
            core_nrst_out <= (state_nx == S_DONE);
            if (reload_go) begin
                cnt_lo           <= '0;
                n_words          <= '0;
                xsum             <= '0;
                word_idx         <= '0;
                bidx             <= '0;
                wbuf             <= '0;
                words_loaded_out <= '0;
            end else if (xfer) begin
                case (state)
                    S_HDR_LO: cnt_lo <= byte_data_in;
                    S_HDR_HI: n_words <= hdr_n[INDEX:0];
                    S_DATA: begin
                        xsum <= xsum ^ byte_data_in;
                        bidx <= bidx + 2'd1;
                        unique case (bidx)
                            2'd0: wbuf[7:0]   <= byte_data_in;
                            2'd1: wbuf[15:8]  <= byte_data_in;
                            2'd2: wbuf[23:16] <= byte_data_in;
                            2'd3: begin
                                imem_we_out      <= 1'b1;
                                imem_addr_out    <= word_idx[INDEX-1:0];
                                imem_data_out    <= {byte_data_in, wbuf};
                                word_idx         <= idx_inc;
                                words_loaded_out <= words_loaded_out +
                                                    (INDEX+1)'(1);
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: table vectors, corner sequences and random frames
// checked against a frame-level reference model.
module tb_imem_boot_loader;

    localparam int INDEX = 6;
    localparam int DEPTH = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             byte_valid = 1'b0;
    logic [7:0]       byte_data = '0;
    logic             byte_ready;
    logic             reload = 1'b0;
    logic             imem_we;
    logic [INDEX-1:0] imem_addr;
    logic [31:0]      imem_data;
    logic             core_nrst;
    logic             done;
    logic             err;
    logic [INDEX:0]   words_loaded;

    int checks = 0;
    int errors = 0;

    imem_boot_loader #(.WIDTH(32), .INDEX(INDEX)) dut (
        .clk_in(clk),
        .nrst_in(rst_n),
        .byte_valid_in(byte_valid),
        .byte_data_in(byte_data),
        .byte_ready_out(byte_ready),
        .reload_in(reload),
        .imem_we_out(imem_we),
        .imem_addr_out(imem_addr),
        .imem_data_out(imem_data),
        .core_nrst_out(core_nrst),
        .done_out(done),
        .err_out(err),
        .words_loaded_out(words_loaded)
    );

    always #5 clk = ~clk;

    logic [7:0]  stream[$];
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_st;
    int          exp_len;
    int          got_addr[$];
    logic [31:0] got_data[$];

    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            got_addr.push_back(int'(imem_addr));
            got_data.push_back(imem_data);
        end
    end

    typedef struct packed {
        logic [0:11][7:0] b;
        logic [7:0]       len;
        logic             done;
        logic             err;
        logic [7:0]       words;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // Frame-level model: exp_st 0=still loading, 1=done, 2=error.
    function automatic void model_run();
        int n;
        int need;
        logic [7:0] cs;
        exp_addr.delete();
        exp_data.delete();
        exp_st  = 0;
        exp_len = stream.size();
        if (stream.size() < 2) return;
        n = int'({stream[1], stream[0]});
        if (n > DEPTH) begin
            exp_st  = 2;
            exp_len = 2;
            return;
        end
        need = 3 + 4 * n;
        cs = 8'h00;
        for (int k = 0; k < n; k++) begin
            if (2 + 4 * k + 3 < stream.size()) begin
                exp_addr.push_back(k);
                exp_data.push_back({stream[2+4*k+3], stream[2+4*k+2],
                                    stream[2+4*k+1], stream[2+4*k]});
            end
        end
        for (int i = 2; i < 2 + 4 * n && i < stream.size(); i++)
            cs ^= stream[i];
        if (stream.size() >= need) begin
            exp_len = need;
            exp_st  = (stream[need-1] == cs) ? 1 : 2;
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input int duty);
        while (duty > 0 && $urandom_range(99) < duty) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        chk("ready_before_byte", 32'(byte_ready), 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = $urandom_range(255);
    endtask

    task automatic finish_frame(input string tag);
        int nw;
        repeat (3) @(negedge clk);
        chk({tag, "_nwrites"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        nw = (got_addr.size() < exp_addr.size()) ? got_addr.size()
                                                 : exp_addr.size();
        for (int i = 0; i < nw; i++) begin
            chk({tag, "_waddr"}, 32'(got_addr[i]), 32'(exp_addr[i]));
            chk({tag, "_wdata"}, got_data[i], exp_data[i]);
        end
        chk({tag, "_done"}, 32'(done), 32'(exp_st == 1));
        chk({tag, "_err"}, 32'(err), 32'(exp_st == 2));
        chk({tag, "_core_nrst"}, 32'(core_nrst), 32'(exp_st == 1));
        chk({tag, "_words"}, 32'(words_loaded), 32'(exp_addr.size()));
        chk({tag, "_ready"}, 32'(byte_ready), 32'(exp_st == 0));
        if (exp_st != 0) begin
            reload = 1'b1;
            @(negedge clk);
            reload = 1'b0;
            chk({tag, "_rl_core_nrst"}, 32'(core_nrst), 32'd0);
            chk({tag, "_rl_ready"}, 32'(byte_ready), 32'd1);
            chk({tag, "_rl_flags"}, 32'({done, err}), 32'd0);
            chk({tag, "_rl_words"}, 32'(words_loaded), 32'd0);
        end
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic run_frame(input string tag, input int duty);
        model_run();
        for (int i = 0; i < exp_len; i++) send_byte(stream[i], duty);
        finish_frame(tag);
    endtask

    task automatic load_vec(input int v);
        stream.delete();
        for (int i = 0; i < int'(vecs[v].len); i++)
            stream.push_back(vecs[v].b[i]);
    endtask

    initial begin
        vecs[0] = '{b: {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                        8'h93, 8'h00, 8'h10, 8'h00, 8'h90, 8'h00},
                    len: 8'd11, done: 1'b1, err: 1'b0, words: 8'd2};
        vecs[1] = '{b: {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                        8'h93, 8'h00, 8'h10, 8'h00, 8'h91, 8'h00},
                    len: 8'd11, done: 1'b0, err: 1'b1, words: 8'd2};
        vecs[2] = '{b: {8'h41, 8'h00, 80'h0},
                    len: 8'd2, done: 1'b0, err: 1'b1, words: 8'd0};
        vecs[3] = '{b: {8'h00, 8'h00, 8'h00, 72'h0},
                    len: 8'd3, done: 1'b1, err: 1'b0, words: 8'd0};
        vecs[4] = '{b: {8'h00, 8'h00, 8'h01, 72'h0},
                    len: 8'd3, done: 1'b0, err: 1'b1, words: 8'd0};
        vecs[5] = '{b: {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                        8'h08, 40'h0},
                    len: 8'd7, done: 1'b1, err: 1'b0, words: 8'd1};
        vecs[6] = '{b: {8'h00, 8'h01, 80'h0},
                    len: 8'd2, done: 1'b0, err: 1'b1, words: 8'd0};

        repeat (3) @(negedge clk);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_core_nrst", 32'(core_nrst), 32'd0);
        chk("rst_flags", 32'({done, err}), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        chk("rst_addr_data", {26'd0, imem_addr} | imem_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(byte_ready), 32'd1);

        for (int v = 0; v < 7; v++) begin
            load_vec(v);
            model_run();
            for (int i = 0; i < exp_len; i++) send_byte(stream[i], 0);
            repeat (3) @(negedge clk);
            chk("tbl_done", 32'(done), 32'(vecs[v].done));
            chk("tbl_err", 32'(err), 32'(vecs[v].err));
            chk("tbl_words", 32'(words_loaded), 32'(vecs[v].words));
            finish_frame("tbl");
        end

        for (int r = 0; r < 4; r++) begin
            load_vec(0);
            run_frame("gaps", 50);
        end

        load_vec(0);
        model_run();
        for (int i = 0; i < 3; i++) send_byte(stream[i], 0);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        for (int i = 3; i < exp_len; i++) send_byte(stream[i], 0);
        finish_frame("reload_ignored");

        load_vec(0);
        for (int i = 0; i < 6; i++) send_byte(stream[i], 0);
        chk("lat_we", 32'(imem_we), 32'd1);
        chk("lat_addr", 32'(imem_addr), 32'd0);
        chk("lat_data", imem_data, 32'h0000_0013);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(imem_we), 32'd0);
        chk("arst_data", imem_data, 32'd0);
        chk("arst_words", 32'(words_loaded), 32'd0);
        chk("arst_core", 32'(core_nrst), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        got_addr.delete();
        got_data.delete();
        @(negedge clk);
        chk("arst_ready", 32'(byte_ready), 32'd1);
        run_frame("after_reset", 0);

        for (int r = 0; r < 25; r++) begin
            int n;
            int mode;
            logic [7:0] cs;
            logic [7:0] bt;
            mode = $urandom_range(9);
            if (mode == 0)      n = DEPTH + 1 + $urandom_range(300);
            else if (mode == 1) n = DEPTH;
            else                n = $urandom_range(DEPTH);
            stream.delete();
            stream.push_back(n[7:0]);
            stream.push_back(n[15:8]);
            cs = 8'h00;
            if (n <= DEPTH) begin
                for (int i = 0; i < 4 * n; i++) begin
                    bt = 8'($urandom_range(255));
                    stream.push_back(bt);
                    cs ^= bt;
                end
                if ($urandom_range(4) == 0)
                    cs ^= 8'(1 << $urandom_range(7));
                stream.push_back(cs);
            end
            run_frame("rand", $urandom_range(60));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
